// File: rtl/wr_spll_pi_filter_mc.sv
// wr_spll_pi_filter_mc: shared, time-multiplexed PI loop filter for up to
// eight SoftPLL channels. Each channel posts signed phase-error samples; a
// four-state scheduler (IDLE/MULT/ACC/OUT) services one channel at a time in
// round-robin order. For every serviced sample it produces a biased,
// saturated DAC word, a one-cycle load strobe and a lock flag.
//
// Strobe semantics: err_valid_i[c] is a single-cycle strobe with no back-pressure.
// A sample that is still pending when a new one arrives is replaced, and
// err_drop_o[c] reports that on the following cycle.
module wr_spll_pi_filter_mc #(
   parameter int                   N_CHANNELS  = 2,
   parameter int                   ERR_WIDTH   = 16,
   parameter int                   DAC_WIDTH   = 16,
   parameter int                   GAIN_WIDTH  = 16,
   parameter int                   FRAC_BITS   = 12,
   parameter int                   INTEG_WIDTH = 32,
   parameter logic [DAC_WIDTH-1:0] DAC_BIAS    = 16'h8000,
   parameter int                   LOCK_THR    = 8,
   parameter int                   LOCK_CNT    = 4
) (
   input  logic                            clk_sys,
   input  logic                            rst_n,
   input  logic [N_CHANNELS-1:0]           ch_enable_i,
   input  logic [N_CHANNELS-1:0]           err_valid_i,
   input  logic [N_CHANNELS*ERR_WIDTH-1:0] err_i,
   input  logic [GAIN_WIDTH-1:0]           kp_i,
   input  logic [GAIN_WIDTH-1:0]           ki_i,
   output logic [N_CHANNELS*DAC_WIDTH-1:0] dac_data_o,
   output logic [N_CHANNELS-1:0]           dac_load_o,
   output logic [N_CHANNELS-1:0]           err_drop_o,
   output logic [N_CHANNELS-1:0]           locked_o
);

   // Product width: unsigned gain plus a sign bit times the signed error.
   localparam int PROD_W = ERR_WIDTH + GAIN_WIDTH + 1;
   // Sum width: one bit wider than either addend, so additions cannot overflow.
   localparam int SUM_W  = ((INTEG_WIDTH > PROD_W) ? INTEG_WIDTH : PROD_W) + 1;
   // Output width: room for the shifted sum plus the unsigned bias.
   localparam int Y_W    = ((SUM_W > DAC_WIDTH + 1) ? SUM_W : DAC_WIDTH + 1) + 1;
   localparam int CH_W   = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
   localparam int CNT_W  = $clog2(LOCK_CNT + 1);

   localparam logic signed [SUM_W-1:0] INTEG_MAX =
      {{(SUM_W - INTEG_WIDTH + 1){1'b0}}, {(INTEG_WIDTH - 1){1'b1}}};
   localparam logic signed [SUM_W-1:0] INTEG_MIN =
      {{(SUM_W - INTEG_WIDTH + 1){1'b1}}, {(INTEG_WIDTH - 1){1'b0}}};
   localparam logic signed [Y_W-1:0]   DAC_MAX  = {{(Y_W - DAC_WIDTH){1'b0}}, {DAC_WIDTH{1'b1}}};
   localparam logic signed [Y_W-1:0]   BIAS_EXT = {{(Y_W - DAC_WIDTH){1'b0}}, DAC_BIAS};
   localparam logic signed [ERR_WIDTH:0] LOCK_THR_V = (ERR_WIDTH + 1)'(LOCK_THR);
   localparam logic [CNT_W-1:0]        LOCK_CNT_V = CNT_W'(LOCK_CNT);

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_ACC, S_OUT} state_t;

   state_t                        state_q, state_d;
   logic [CH_W-1:0]               rr_q, rr_d;
   logic [CH_W-1:0]               cur_q, cur_d;
   logic                          abort_q, abort_d;
   logic signed [ERR_WIDTH-1:0]   err_cur_q, err_cur_d;
   logic signed [PROD_W-1:0]      p_q, p_d;
   logic signed [PROD_W-1:0]      s_q, s_d;
   logic signed [ERR_WIDTH-1:0]   pend_q [N_CHANNELS];
   logic signed [ERR_WIDTH-1:0]   pend_d [N_CHANNELS];
   logic [N_CHANNELS-1:0]         pend_v_q, pend_v_d;
   logic signed [INTEG_WIDTH-1:0] integ_q [N_CHANNELS];
   logic signed [INTEG_WIDTH-1:0] integ_d [N_CHANNELS];
   logic [CNT_W-1:0]              cnt_q [N_CHANNELS];
   logic [CNT_W-1:0]              cnt_d [N_CHANNELS];
   logic [DAC_WIDTH-1:0]          dac_q [N_CHANNELS];
   logic [DAC_WIDTH-1:0]          dac_d [N_CHANNELS];
   logic [N_CHANNELS-1:0]         load_q, load_d;
   logic [N_CHANNELS-1:0]         drop_q, drop_d;
   logic [N_CHANNELS-1:0]         locked_q, locked_d;

   logic                          pick_found;
   logic [CH_W-1:0]               pick_idx;
   logic signed [SUM_W-1:0]       acc_sum;
   logic signed [SUM_W-1:0]       out_sum;
   logic signed [Y_W-1:0]         y;
   logic signed [ERR_WIDTH:0]     err_abs;
   logic [CNT_W-1:0]              cnt_new;
   int                            idx;

   // Next-state logic: round-robin pick, MAC pipeline, capture, and disable.
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      cur_d      = cur_q;
      abort_d    = abort_q;
      err_cur_d  = err_cur_q;
      p_d        = p_q;
      s_d        = s_q;
      pend_d     = pend_q;
      pend_v_d   = pend_v_q;
      integ_d    = integ_q;
      cnt_d      = cnt_q;
      dac_d      = dac_q;
      locked_d   = locked_q;
      load_d     = '0;
      drop_d     = '0;
      pick_found = 1'b0;
      pick_idx   = '0;
      acc_sum    = '0;
      out_sum    = '0;
      y          = '0;
      err_abs    = '0;
      cnt_new    = '0;
      idx        = 0;

      // First enabled, pending channel at or above the RR pointer, with wrap.
      for (int i = 0; i < N_CHANNELS; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= N_CHANNELS) idx = idx - N_CHANNELS;
         if (!pick_found && pend_v_q[idx] && ch_enable_i[idx]) begin
            pick_found = 1'b1;
            pick_idx   = CH_W'(idx);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               cur_d              = pick_idx;
               err_cur_d          = pend_q[pick_idx];
               pend_v_d[pick_idx] = 1'b0;
               abort_d            = 1'b0;
               state_d            = S_MULT;
            end
         end
         S_MULT: begin
            // Gains are sampled here, so changes apply from the next sample.
            p_d     = PROD_W'($signed({1'b0, kp_i})) * PROD_W'(err_cur_q);
            s_d     = PROD_W'($signed({1'b0, ki_i})) * PROD_W'(err_cur_q);
            state_d = S_ACC;
         end
         S_ACC: begin
            acc_sum = SUM_W'(integ_q[cur_q]) + SUM_W'(s_q);
            if (!abort_q) begin
               if (acc_sum > INTEG_MAX)      integ_d[cur_q] = INTEG_WIDTH'(INTEG_MAX);
               else if (acc_sum < INTEG_MIN) integ_d[cur_q] = INTEG_WIDTH'(INTEG_MIN);
               else                          integ_d[cur_q] = INTEG_WIDTH'(acc_sum);
            end
            state_d = S_OUT;
         end
         default: begin
            out_sum = SUM_W'(p_q) + SUM_W'(integ_q[cur_q]);
            y       = (Y_W'(out_sum) >>> FRAC_BITS) + BIAS_EXT;
            err_abs = (err_cur_q < 0) ? -(ERR_WIDTH + 1)'(err_cur_q) : (ERR_WIDTH + 1)'(err_cur_q);
            if (err_abs <= LOCK_THR_V)
               cnt_new = (cnt_q[cur_q] == LOCK_CNT_V) ? cnt_q[cur_q] : cnt_q[cur_q] + 1'b1;
            else
               cnt_new = '0;
            if (!abort_q && ch_enable_i[cur_q]) begin
               if (y < 0)             dac_d[cur_q] = '0;
               else if (y > DAC_MAX)  dac_d[cur_q] = {DAC_WIDTH{1'b1}};
               else                   dac_d[cur_q] = y[DAC_WIDTH-1:0];
               load_d[cur_q]   = 1'b1;
               cnt_d[cur_q]    = cnt_new;
               locked_d[cur_q] = (cnt_new == LOCK_CNT_V);
            end
            rr_d    = (int'(cur_q) == N_CHANNELS - 1) ? '0 : cur_q + 1'b1;
            state_d = S_IDLE;
         end
      endcase

      // A channel disabled while in flight must not touch state or outputs later.
      if ((state_q == S_MULT || state_q == S_ACC) && !ch_enable_i[cur_q]) abort_d = 1'b1;

      // Capture; a sample consumed this cycle is not a drop.
      for (int c = 0; c < N_CHANNELS; c++) begin
         if (err_valid_i[c] && ch_enable_i[c]) begin
            if (pend_v_q[c] && !(state_q == S_IDLE && pick_found && int'(pick_idx) == c))
               drop_d[c] = 1'b1;
            pend_d[c]   = err_i[c*ERR_WIDTH +: ERR_WIDTH];
            pend_v_d[c] = 1'b1;
         end
      end

      // Disabled channels are held at their reset-like idle values.
      for (int c = 0; c < N_CHANNELS; c++) begin
         if (!ch_enable_i[c]) begin
            pend_v_d[c] = 1'b0;
            integ_d[c]  = '0;
            cnt_d[c]    = '0;
            locked_d[c] = 1'b0;
            dac_d[c]    = DAC_BIAS;
            load_d[c]   = 1'b0;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rr_q      <= '0;
         cur_q     <= '0;
         abort_q   <= 1'b0;
         err_cur_q <= '0;
         p_q       <= '0;
         s_q       <= '0;
         pend_v_q  <= '0;
         load_q    <= '0;
         drop_q    <= '0;
         locked_q  <= '0;
         for (int c = 0; c < N_CHANNELS; c++) begin
            pend_q[c]  <= '0;
            integ_q[c] <= '0;
            cnt_q[c]   <= '0;
            dac_q[c]   <= DAC_BIAS;
         end
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         cur_q     <= cur_d;
         abort_q   <= abort_d;
         err_cur_q <= err_cur_d;
         p_q       <= p_d;
         s_q       <= s_d;
         pend_v_q  <= pend_v_d;
         load_q    <= load_d;
         drop_q    <= drop_d;
         locked_q  <= locked_d;
         pend_q    <= pend_d;
         integ_q   <= integ_d;
         cnt_q     <= cnt_d;
         dac_q     <= dac_d;
      end
   end

   for (genvar g = 0; g < N_CHANNELS; g++) begin : g_pack
      assign dac_data_o[g*DAC_WIDTH +: DAC_WIDTH] = dac_q[g];
   end

   assign dac_load_o = load_q;
   assign err_drop_o = drop_q;
   assign locked_o   = locked_q;

endmodule

// File: tb/tb_wr_spll_pi_filter_mc.sv
// Bench for wr_spll_pi_filter_mc: directed samples, a transaction-level
// model that schedules expected loads/drops/disables by cycle, and a compare
// process that checks every output on every cycle.
module tb_wr_spll_pi_filter_mc;

   localparam int N  = 2;
   localparam int EW = 16;
   localparam int DW = 16;
   localparam int GW = 16;

   logic              clk_sys = 1'b0;
   logic              rst_n   = 1'b0;
   logic [N-1:0]      ch_enable_i;
   logic [N-1:0]      err_valid_i;
   logic [N*EW-1:0]   err_i;
   logic [GW-1:0]     kp_i;
   logic [GW-1:0]     ki_i;
   logic [N*DW-1:0]   dac_data_o;
   logic [N-1:0]      dac_load_o;
   logic [N-1:0]      err_drop_o;
   logic [N-1:0]      locked_o;

   wr_spll_pi_filter_mc dut (
      .clk_sys     (clk_sys),
      .rst_n       (rst_n),
      .ch_enable_i (ch_enable_i),
      .err_valid_i (err_valid_i),
      .err_i       (err_i),
      .kp_i        (kp_i),
      .ki_i        (ki_i),
      .dac_data_o  (dac_data_o),
      .dac_load_o  (dac_load_o),
      .err_drop_o  (err_drop_o),
      .locked_o    (locked_o)
   );

   // Clock and cycle counter (cyc == n for the whole cycle after edge n).
   always #4 clk_sys = ~clk_sys;
   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   logic chk_en = 1'b0;

   typedef struct {
      int            at;
      int            ch;
      int            kind;   // 0 load, 1 drop, 2 disable
      logic [DW-1:0] dac;
      logic          lk;
   } ev_t;
   ev_t ev_q[$];

   longint        m_integ [N];
   int            m_cnt   [N];
   logic [DW-1:0] m_dac   [N];
   logic [N-1:0]  m_lk;
   logic [N-1:0]  exp_load;
   logic [N-1:0]  exp_drop;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin
         m_integ[c] = 0;
         m_cnt[c]   = 0;
         m_dac[c]   = 16'h8000;
      end
      m_lk = '0;
      ev_q.delete();
   endtask

   // Serviced sample: PI arithmetic on plain integers, lock counting, scheduled load.
   function automatic logic [DW-1:0] model_svc(input int ch, input int e, input int at);
      longint kp, ki, p, acc, y;
      int     a;
      ev_t    ev;
      kp  = kp_i;
      ki  = ki_i;
      p   = kp * e;
      acc = m_integ[ch] + ki * e;
      if (acc > 64'sd2147483647)  acc = 64'sd2147483647;
      if (acc < -64'sd2147483648) acc = -64'sd2147483648;
      m_integ[ch] = acc;
      y = ((p + acc) >>> 12) + 32768;
      if (y < 0)     y = 0;
      if (y > 65535) y = 65535;
      a = (e < 0) ? -e : e;
      if (a <= 8) m_cnt[ch] = (m_cnt[ch] < 4) ? m_cnt[ch] + 1 : 4;
      else        m_cnt[ch] = 0;
      ev.at = at; ev.ch = ch; ev.kind = 0; ev.dac = DW'(y); ev.lk = (m_cnt[ch] == 4);
      ev_q.push_back(ev);
      return DW'(y);
   endfunction

   task automatic model_event(input int ch, input int kind, input int at);
      ev_t ev;
      ev.at = at; ev.ch = ch; ev.kind = kind; ev.dac = 16'h8000; ev.lk = 1'b0;
      if (kind == 2) begin
         m_integ[ch] = 0;
         m_cnt[ch]   = 0;
      end
      ev_q.push_back(ev);
   endtask

   // Compare process: apply events due this cycle, then check all outputs.
   always @(negedge clk_sys) begin
      if (chk_en) begin
         exp_load = '0;
         exp_drop = '0;
         for (int i = ev_q.size() - 1; i >= 0; i--) begin
            if (ev_q[i].at == cyc) begin
               case (ev_q[i].kind)
                  0: begin
                     m_dac[ev_q[i].ch]    = ev_q[i].dac;
                     m_lk[ev_q[i].ch]     = ev_q[i].lk;
                     exp_load[ev_q[i].ch] = 1'b1;
                  end
                  1: exp_drop[ev_q[i].ch] = 1'b1;
                  default: begin
                     m_dac[ev_q[i].ch] = 16'h8000;
                     m_lk[ev_q[i].ch]  = 1'b0;
                  end
               endcase
               ev_q.delete(i);
            end
         end
         for (int c = 0; c < N; c++)
            chk($sformatf("dac%0d@%0d", c, cyc), 64'(dac_data_o[c*DW +: DW]), 64'(m_dac[c]));
         chk($sformatf("load@%0d", cyc), 64'(dac_load_o), 64'(exp_load));
         chk($sformatf("drop@%0d", cyc), 64'(err_drop_o), 64'(exp_drop));
         chk($sformatf("locked@%0d", cyc), 64'(locked_o), 64'(m_lk));
      end
   end

   task automatic step_to(input int n);
      while (cyc < n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic drive(input int ch, input int e);
      err_valid_i[ch]        = 1'b1;
      err_i[ch*EW +: EW]     = EW'(e);
   endtask

   task automatic send(input int ch, input int e);
      err_valid_i = '0;
      drive(ch, e);
      step_to(cyc + 1);
      err_valid_i = '0;
   endtask

   // One isolated sample on an idle FSM, with literal expectations.
   task automatic one(input int ch, input int e, input logic [DW-1:0] lit, input logic lk,
                      input int gap, input string nm);
      int            t0;
      logic [DW-1:0] v;
      t0 = cyc;
      v  = model_svc(ch, e, t0 + 5);
      chk({nm, "_model"}, 64'(v), 64'(lit));
      send(ch, e);
      step_to(t0 + 5);
      chk({nm, "_dac"}, 64'(dac_data_o[ch*DW +: DW]), 64'(lit));
      chk({nm, "_load"}, 64'(dac_load_o[ch]), 64'd1);
      chk({nm, "_lock"}, 64'(locked_o[ch]), 64'(lk));
      step_to(t0 + gap);
   endtask

   task automatic clear_ch(input int ch);
      int t0;
      t0 = cyc;
      ch_enable_i[ch] = 1'b0;
      model_event(ch, 2, t0 + 1);
      step_to(t0 + 3);
      ch_enable_i[ch] = 1'b1;
      step_to(t0 + 5);
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_dac"}, 64'(dac_data_o), 64'({16'h8000, 16'h8000}));
      chk({nm, "_load"}, 64'(dac_load_o), 64'd0);
      chk({nm, "_drop"}, 64'(err_drop_o), 64'd0);
      chk({nm, "_locked"}, 64'(locked_o), 64'd0);
   endtask

   initial begin
      int t0;
      ch_enable_i = '0;
      err_valid_i = '0;
      err_i       = '0;
      kp_i        = '0;
      ki_i        = '0;
      model_reset();
      repeat (3) @(posedge clk_sys);
      #1;
      check_reset_vals("reset");
      rst_n       = 1'b1;
      ch_enable_i = '1;
      step_to(cyc + 2);
      chk_en = 1'b1;

      // Proportional path
      kp_i = 16'd4096; ki_i = 16'd0;
      one(0, 100,  16'h8064, 1'b0, 8, "p_pos");
      one(0, -100, 16'h7F9C, 1'b0, 8, "p_neg");

      // Integral path
      kp_i = 16'd0; ki_i = 16'd4096;
      one(0, 10, 16'h800A, 1'b0, 10, "i_1");
      one(0, 10, 16'h8014, 1'b0, 10, "i_2");
      one(0, 10, 16'h801E, 1'b0, 10, "i_3");
      clear_ch(0);

      // Output clamps and integrator saturation
      kp_i = 16'd65535; ki_i = 16'd0;
      one(0, 32767,  16'hFFFF, 1'b0, 8, "sat_hi");
      one(0, -32768, 16'h0000, 1'b0, 8, "sat_lo");
      kp_i = 16'd0; ki_i = 16'd65535;
      one(0, 32767,  16'hFFFF, 1'b0, 8, "isat_1");
      one(0, 32767,  16'hFFFF, 1'b0, 8, "isat_2");
      one(0, -32768, 16'h8007, 1'b0, 8, "isat_back");
      clear_ch(0);

      // Lock detection
      kp_i = 16'd4096; ki_i = 16'd0;
      one(0, 3,   16'h8003, 1'b0, 8, "lk_1");
      one(0, -5,  16'h7FFB, 1'b0, 8, "lk_2");
      one(0, 8,   16'h8008, 1'b0, 8, "lk_3");
      one(0, 0,   16'h8000, 1'b1, 8, "lk_4");
      one(0, 100, 16'h8064, 1'b0, 8, "lk_lost");

      // Channel 1 alone, which also returns the RR pointer to channel 0
      one(1, 50, 16'h8032, 1'b0, 8, "ch1");

      // Round robin and overrun
      t0 = cyc;
      chk("rr_m0", 64'(model_svc(0, 20, t0 + 5)), 64'h8014);
      chk("rr_m1", 64'(model_svc(1, -20, t0 + 9)), 64'h7FEC);
      model_event(0, 1, t0 + 7);
      chk("rr_m2", 64'(model_svc(0, 30, t0 + 13)), 64'h801E);
      drive(0, 20);
      drive(1, -20);
      step_to(t0 + 1);
      err_valid_i = '0;
      step_to(t0 + 5);
      chk("rr_ch0_dac", 64'(dac_data_o[0 +: DW]), 64'h8014);
      chk("rr_ch0_load", 64'(dac_load_o), 64'b01);
      drive(0, 77);
      step_to(t0 + 6);
      drive(0, 30);
      step_to(t0 + 7);
      err_valid_i = '0;
      chk("ovr_drop", 64'(err_drop_o), 64'b01);
      step_to(t0 + 9);
      chk("rr_ch1_dac", 64'(dac_data_o[DW +: DW]), 64'h7FEC);
      chk("rr_ch1_load", 64'(dac_load_o), 64'b10);
      step_to(t0 + 13);
      chk("ovr_ch0_dac", 64'(dac_data_o[0 +: DW]), 64'h801E);
      chk("ovr_ch0_load", 64'(dac_load_o), 64'b01);
      step_to(t0 + 16);

      // Disable during MULT
      kp_i = 16'd0; ki_i = 16'd4096;
      one(0, 10, 16'h800A, 1'b0, 8, "dis_pre");
      t0 = cyc;
      send(0, 10);
      step_to(t0 + 2);
      ch_enable_i[0] = 1'b0;
      model_event(0, 2, t0 + 3);
      step_to(t0 + 5);
      chk("dis_noload", 64'(dac_load_o), 64'd0);
      chk("dis_dac", 64'(dac_data_o[0 +: DW]), 64'h8000);
      step_to(t0 + 6);
      ch_enable_i[0] = 1'b1;
      step_to(t0 + 8);
      one(0, 10, 16'h800A, 1'b0, 8, "dis_reen");

      // Reset during ACC
      t0 = cyc;
      send(1, 40);
      step_to(t0 + 3);
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      step_to(t0 + 5);
      check_reset_vals("rst_hold");
      rst_n = 1'b1;
      model_reset();
      chk_en = 1'b1;
      step_to(t0 + 14);
      one(0, 10, 16'h800A, 1'b0, 8, "post_rst");

      step_to(cyc + 4);
      chk("events_left", 64'(ev_q.size()), 64'd0);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
